// File: rtl/cam_stream_gen.sv
// cam_stream_gen: OV7670-style parallel camera transmitter (pclk, vsync, href, RGB565 bytes)
// driven by an internal test-pattern generator. Define CAM_STREAM_EXT_EN for an external pixel source.
module cam_stream_gen #(
  parameter int H_PIXELS    = 320,
  parameter int V_LINES     = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int CLK_DIV     = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        enable_in,
  input  logic [1:0]  pattern_sel_in,
`ifdef CAM_STREAM_EXT_EN
  output logic        pixel_req_out,
  input  logic [15:0] pixel_in,
`endif
  output logic        pclk_out,
  output logic        vsync_out,
  output logic        href_out,
  output logic [7:0]  data_out,
  output logic        frame_done_out
);

  localparam int LT      = 2 * H_PIXELS + H_BLANK;
  localparam int ACT_B   = 2 * H_PIXELS;
  localparam int VS_T    = VSYNC_LINES * LT;
  localparam int VB_T    = V_BACK * LT;
  localparam int VF_T    = V_FRONT * LT;
  localparam int FRAME_T = (VSYNC_LINES + V_BACK + V_LINES + V_FRONT) * LT;
  localparam int CNT_W   = $clog2(FRAME_T + 1);
  localparam int HW      = $clog2(LT);
  localparam int XW      = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW      = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int HALF    = CLK_DIV / 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFRONT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               pclk_q, pclk_d;
  logic               tick;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]      hcnt_q, hcnt_d;
  logic [YW-1:0]      line_q, line_d;
  logic [1:0]         pat_q, pat_d;
  logic               vsync_q, vsync_d;
  logic               href_q, href_d;
  logic [7:0]         data_q, data_d;
  logic               fd_q, fd_d;
  logic [15:0]        pix;
  logic               req_d;

`ifdef CAM_STREAM_EXT_EN
  logic               req_q;
  logic [DIV_W-1:0]   sdly_q;
  logic [15:0]        ext_q;
  logic [15:0]        hold_q;
`endif

  function automatic logic [15:0] pattern_pix(input logic [1:0] sel,
                                               input logic [XW-1:0] x,
                                               input logic [YW-1:0] y);
    logic [XW+2:0] x8;
    logic [2:0]    bar;
    logic [7:0]    xe;
    logic [7:0]    ye;
    logic [15:0]   c;
    x8  = {x, 3'b000};
    bar = 3'(x8 / (XW+3)'(H_PIXELS));
    xe  = 8'(x);
    ye  = 8'(y);
    case (sel)
      2'd0: begin
        case (bar)
          3'd0:    c = 16'hFFFF;
          3'd1:    c = 16'hFFE0;
          3'd2:    c = 16'h07FF;
          3'd3:    c = 16'h07E0;
          3'd4:    c = 16'hF81F;
          3'd5:    c = 16'hF800;
          3'd6:    c = 16'h001F;
          default: c = 16'h0000;
        endcase
      end
      2'd1:    c = {xe[4:0], xe[5:0], xe[4:0]};
      2'd2:    c = (xe[4] ^ ye[4]) ? 16'hFFFF : 16'h0000;
      default: c = {ye, xe};
    endcase
    return c;
  endfunction

  // pclk divider: pclk_out falls on the same edge that advances the frame timing
  always_comb begin
    tick   = (div_q == DIV_W'(CLK_DIV - 1));
    div_d  = tick ? '0 : div_q + 1'b1;
    pclk_d = (div_d >= DIV_W'(HALF));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_q   <= '0;
      pclk_q  <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      line_q  <= '0;
      pat_q   <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= '0;
      fd_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      pclk_q  <= pclk_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      line_q  <= line_d;
      pat_q   <= pat_d;
      fd_q    <= fd_d;
      if (tick) begin
        vsync_q <= vsync_d;
        href_q  <= href_d;
        data_q  <= data_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    line_d  = line_q;
    pat_d   = pat_q;
    fd_d    = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (enable_in) begin
            state_d = S_VSYNC;
            pat_d   = pattern_sel_in;
            cnt_d   = '0;
          end
        end
        S_VSYNC: begin
          if (cnt_q == CNT_W'(VS_T - 1)) begin
            state_d = S_VBACK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_VBACK: begin
          if (cnt_q == CNT_W'(VB_T - 1)) begin
            state_d = S_ACTIVE;
            cnt_d   = '0;
            hcnt_d  = '0;
            line_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_ACTIVE: begin
          if (hcnt_q == HW'(ACT_B - 1) && line_q == YW'(V_LINES - 1)) begin
            fd_d = 1'b1;
          end
          if (hcnt_q == HW'(LT - 1)) begin
            hcnt_d = '0;
            if (line_q == YW'(V_LINES - 1)) begin
              state_d = S_VFRONT;
              cnt_d   = '0;
              line_d  = '0;
            end else begin
              line_d = line_q + 1'b1;
            end
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        S_VFRONT: begin
          if (cnt_q == CNT_W'(VF_T - 1)) begin
            cnt_d = '0;
            if (enable_in) begin
              state_d = S_VSYNC;
              pat_d   = pattern_sel_in;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are derived from the next state so they register on the tick edge itself
  always_comb begin
    vsync_d = (state_d == S_VSYNC);
    href_d  = (state_d == S_ACTIVE) && (hcnt_d < HW'(ACT_B));
    req_d   = href_d && !hcnt_d[0];
    pix     = pattern_pix(pat_d, XW'(hcnt_d >> 1), line_d);
`ifdef CAM_STREAM_EXT_EN
    if (pat_d == 2'd3) begin
      pix = hcnt_d[0] ? hold_q : ext_q;
    end
`endif
    if (href_d) begin
      data_d = hcnt_d[0] ? pix[7:0] : pix[15:8];
    end else begin
      data_d = 8'h00;
    end
  end

`ifdef CAM_STREAM_EXT_EN
  // External pixels trail their request by one pixel slot; hold_q keeps both bytes together
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      req_q  <= 1'b0;
      sdly_q <= '0;
      ext_q  <= '0;
      hold_q <= '0;
    end else begin
      req_q <= tick && req_d;
      if (tick && req_d) begin
        sdly_q <= DIV_W'(HALF);
        hold_q <= ext_q;
      end else if (sdly_q != '0) begin
        sdly_q <= sdly_q - 1'b1;
        if (sdly_q == DIV_W'(1)) begin
          ext_q <= pixel_in;
        end
      end
    end
  end

  assign pixel_req_out = req_q;
`else
  logic unused_req;
  assign unused_req = req_d;
`endif

  assign pclk_out       = pclk_q;
  assign vsync_out      = vsync_q;
  assign href_out       = href_q;
  assign data_out       = data_q;
  assign frame_done_out = fd_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Self-checking bench for cam_stream_gen: small-geometry instance against a byte scoreboard,
// plus a default-geometry instance for the colour-bar content of the first line.
module tb_cam_stream_gen;

  localparam int SH = 4, SV = 2, SHB = 4, SVS = 1, SVB = 1, SVF = 1, SDIV = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_s, en_s, pclk_s, vs_s, href_s, fd_s;
  logic [1:0] pat_s;
  logic [7:0] data_s;
  logic       rst_n_d, en_d, pclk_d, vs_d, href_d, fd_d;
  logic [1:0] pat_d;
  logic [7:0] data_d;

  cam_stream_gen #(
    .H_PIXELS(SH), .V_LINES(SV), .H_BLANK(SHB), .VSYNC_LINES(SVS),
    .V_BACK(SVB), .V_FRONT(SVF), .CLK_DIV(SDIV)
  ) dut_s (
    .clk_in(clk), .rst_n_in(rst_n_s), .enable_in(en_s), .pattern_sel_in(pat_s),
    .pclk_out(pclk_s), .vsync_out(vs_s), .href_out(href_s), .data_out(data_s),
    .frame_done_out(fd_s)
  );

  cam_stream_gen dut_d (
    .clk_in(clk), .rst_n_in(rst_n_d), .enable_in(en_d), .pattern_sel_in(pat_d),
    .pclk_out(pclk_d), .vsync_out(vs_d), .href_out(href_d), .data_out(data_d),
    .frame_done_out(fd_d)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_pix(input int p, input int x, input int y, input int hp);
    logic [15:0] xv, yv, c;
    int bar;
    xv = 16'(x);
    yv = 16'(y);
    case (p)
      0: begin
        bar = (x * 8) / hp;
        case (bar)
          0: c = 16'hFFFF;
          1: c = 16'hFFE0;
          2: c = 16'h07FF;
          3: c = 16'h07E0;
          4: c = 16'hF81F;
          5: c = 16'hF800;
          6: c = 16'h001F;
          default: c = 16'h0000;
        endcase
      end
      1: c = {xv[4:0], xv[5:0], xv[4:0]};
      2: c = (xv[4] ^ yv[4]) ? 16'hFFFF : 16'h0000;
      default: c = {yv[7:0], xv[7:0]};
    endcase
    return c;
  endfunction

  logic [7:0] sb_q[$];

  task automatic push_frame(input int p);
    logic [15:0] px;
    for (int y = 0; y < SV; y++) begin
      for (int x = 0; x < SH; x++) begin
        px = model_pix(p, x, y, SH);
        sb_q.push_back(px[15:8]);
        sb_q.push_back(px[7:0]);
      end
    end
  endtask

  // A frame's expected bytes are queued when it starts, using the pattern the bench was driving
  always @(posedge vs_s) push_frame(int'(pat_s));

  int   cyc = 0;
  logic pclk_pr = 1'b0, vs_pr = 1'b0, href_pr = 1'b0, fd_pr = 1'b0, first_href = 1'b0;
  int   pclk_rise = 0, vs_cnt = 0, href_cnt = 0, fd_cnt = 0, fd_bad = 0;
  int   t_vs_rise = 0, t_vs_prev = 0, t_vs_fall = 0, t_href_rise = 0, t_href_first = 0;
  int   t_href_fall = 0, t_fd = 0, t_fd_prev = 0;

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    pclk_pr <= pclk_s;
    vs_pr   <= vs_s;
    href_pr <= href_s;
    fd_pr   <= fd_s;
    if (pclk_s && !pclk_pr) begin
      pclk_rise <= pclk_rise + 1;
      if (href_s) begin
        if (sb_q.size() == 0) check_val("sb_underflow", sb_q.size(), 1);
        else check_val("byte", data_s, sb_q.pop_front());
      end
    end
    if (vs_s && !vs_pr) begin
      vs_cnt     <= vs_cnt + 1;
      t_vs_prev  <= t_vs_rise;
      t_vs_rise  <= cyc;
      first_href <= 1'b0;
    end
    if (!vs_s && vs_pr) t_vs_fall <= cyc;
    if (href_s && !href_pr) begin
      href_cnt    <= href_cnt + 1;
      t_href_rise <= cyc;
      if (!first_href) begin
        t_href_first <= cyc;
        first_href   <= 1'b1;
      end
    end
    if (!href_s && href_pr) t_href_fall <= cyc;
    if (fd_s) begin
      fd_cnt    <= fd_cnt + 1;
      t_fd_prev <= t_fd;
      t_fd      <= cyc;
      if (!(href_pr && !href_s) || fd_pr) fd_bad <= fd_bad + 1;
    end
  end

  logic [7:0] cap[0:639];
  int         bidx_d = 0;
  logic       pclk_pr_d = 1'b0;

  always @(negedge clk) begin
    pclk_pr_d <= pclk_d;
    if (vs_d) bidx_d <= 0;
    else if (pclk_d && !pclk_pr_d && href_d && bidx_d < 640) begin
      cap[bidx_d] <= data_d;
      bidx_d      <= bidx_d + 1;
    end
  end

  function automatic int evt_cnt(input int which);
    case (which)
      0: return fd_cnt;
      1: return vs_cnt;
      default: return href_cnt;
    endcase
  endfunction

  task automatic wait_evt(input int which, input int n, input int budget, input string tag);
    int target;
    int i;
    target = evt_cnt(which) + n;
    i = 0;
    while (evt_cnt(which) < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (evt_cnt(which) < target) check_val(tag, evt_cnt(which), target);
  endtask

  int   fd0, vs0, pr0;
  logic mid_href;

  initial begin
    rst_n_s = 1'b0; rst_n_d = 1'b0;
    en_s = 1'b0; en_d = 1'b0; pat_s = 2'd0; pat_d = 2'd0;
    repeat (3) @(negedge clk);
    check_val("rst_pclk", pclk_s, 0);
    check_val("rst_vsync", vs_s, 0);
    check_val("rst_href", href_s, 0);
    check_val("rst_data", data_s, 0);
    check_val("rst_fdone", fd_s, 0);

    rst_n_s = 1'b1; rst_n_d = 1'b1;
    en_d = 1'b1; pat_d = 2'd0;
    repeat (20) @(negedge clk);
    check_val("idle_vsync_count", vs_cnt, 0);
    check_val("idle_pclk_rises", pclk_rise, 10);

    pat_s = 2'd3; en_s = 1'b1;
    wait_evt(0, 2, 400, "timeout_first_frames");
    check_val("vsync_len", t_vs_fall - t_vs_rise, 24);
    check_val("href_first_delay", t_href_first - t_vs_rise, 48);
    check_val("href_len", t_href_fall - t_href_rise, 16);
    check_val("frame_period", t_vs_rise - t_vs_prev, 120);
    check_val("fdone_period", t_fd - t_fd_prev, 120);
    check_val("fdone_align", fd_bad, 0);
    check_val("sb_drained_1", sb_q.size(), 0);

    // pattern changes land mid-frame and take effect only on the following frame
    for (int k = 0; k < 3; k++) begin
      wait_evt(1, 1, 200, "timeout_vsync");
      repeat (30) @(negedge clk);
      pat_s = (k == 0) ? 2'd1 : ((k == 1) ? 2'd0 : 2'd2);
      wait_evt(0, 1, 200, "timeout_fdone");
    end
    wait_evt(0, 1, 200, "timeout_fdone_last");
    check_val("sb_drained_2", sb_q.size(), 0);

    wait_evt(2, 1, 200, "timeout_href");
    repeat (3) @(negedge clk);
    en_s = 1'b0;
    fd0 = fd_cnt; vs0 = vs_cnt;
    repeat (200) @(negedge clk);
    check_val("disable_completes_frame", fd_cnt - fd0, 1);
    check_val("disable_no_new_vsync", vs_cnt - vs0, 0);
    check_val("disable_sb_drained", sb_q.size(), 0);
    check_val("idle_vsync_low", vs_s, 0);
    check_val("idle_href_low", href_s, 0);
    pr0 = pclk_rise;
    repeat (20) @(negedge clk);
    check_val("idle_pclk_toggles", pclk_rise - pr0, 10);

    pat_s = 2'd3; en_s = 1'b1;
    wait_evt(2, 1, 200, "timeout_href_rst");
    repeat (2) @(negedge clk);
    #2;
    rst_n_s = 1'b0;
    #1;
    check_val("async_rst_pclk", pclk_s, 0);
    check_val("async_rst_vsync", vs_s, 0);
    check_val("async_rst_href", href_s, 0);
    check_val("async_rst_data", data_s, 0);
    check_val("async_rst_fdone", fd_s, 0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n_s = 1'b1;
    mid_href = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (href_s) mid_href = 1'b1;
      if (vs_s) break;
    end
    check_val("restart_vsync", vs_s, 1);
    check_val("restart_no_midline", mid_href, 0);
    wait_evt(0, 1, 200, "timeout_fdone_rst");
    check_val("sb_drained_3", sb_q.size(), 0);

    while (bidx_d < 640 && cyc < 90000) @(negedge clk);
    if (bidx_d < 640) check_val("timeout_default_line", bidx_d, 640);
    check_val("def_px0_hi", cap[0], 8'hFF);
    check_val("def_px0_lo", cap[1], 8'hFF);
    check_val("def_px40_hi", cap[80], 8'hFF);
    check_val("def_px40_lo", cap[81], 8'hE0);
    check_val("def_px80_hi", cap[160], 8'h07);
    check_val("def_px80_lo", cap[161], 8'hFF);
    check_val("def_px319_hi", cap[638], 8'h00);
    check_val("def_px319_lo", cap[639], 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_stream_gen.md
Name: cam_stream_gen

Overview:
- Transmitter end of the OV7670-style parallel camera interface: generates pclk, vsync, href and 8-bit RGB565 byte data. The camera capture path already receives this exact interface.
- Lets the capture → rotate → frame buffer → VGA chain run in simulation and on the board without the sensor attached; its outputs drive the camera-return nets (jb/ja equivalents).
- Content comes from an internal test-pattern generator; an external pixel source can be compiled in.

Parameters:
- H_PIXELS, 320, active pixels per line (even, ≥2).
- V_LINES, 240, active lines per frame.
- H_BLANK, 144, pclk ticks with href low after each line's active bytes (≥1).
- VSYNC_LINES, 3, line-times with vsync high.
- V_BACK, 17, blank line-times after vsync.
- V_FRONT, 10, blank line-times after the last active line.
- CLK_DIV, 4, clk_in cycles per pclk period (even, ≥2).

Ports:
- clk_in  input  1  system clock (65 MHz)
- rst_n_in  input  1  asynchronous active-low reset
- enable_in  input  1  start/continue generating frames
- pattern_sel_in  input  2  test pattern select
- pclk_out  output  1  generated pixel clock
- vsync_out  output  1  frame sync, active high
- href_out  output  1  line valid, active high
- data_out  output  8  pixel byte
- frame_done_out  output  1  one clk_in pulse at end of each frame's last active line

Behaviour:
- Reset:
  - pclk_out=0, vsync_out=0, href_out=0, data_out=0, frame_done_out=0.
  - State IDLE; all counters 0. Reset acts immediately, including mid-frame.
- pclk:
  - Free-running whenever not in reset: low for CLK_DIV/2 clk_in cycles, then high for CLK_DIV/2.
  - A "tick" is the clk_in cycle in which pclk_out falls.
  - vsync_out, href_out and data_out change only on ticks, so they are stable at every pclk rising edge.
- Line time: LT = 2*H_PIXELS + H_BLANK ticks.
- States:
  - IDLE: at a tick with enable_in=1, latch pattern_sel_in, go to VSYNC.
  - VSYNC: vsync_out=1 for VSYNC_LINES*LT ticks.
  - VBACK: all outputs low for V_BACK*LT ticks.
  - ACTIVE: href_out=1 for 2*H_PIXELS ticks, then low for H_BLANK ticks. Repeat for V_LINES lines.
  - VFRONT: outputs low for V_FRONT*LT ticks.
  - After VFRONT: go to VSYNC if enable_in=1 (re-latch pattern), else IDLE.
- Enable handling:
  - enable_in is sampled only at IDLE and at the VFRONT→VSYNC decision.
  - Deasserting mid-frame always completes the current frame.
- Byte order: per pixel, high byte pixel[15:8] first, then pixel[7:0]. data_out=0 whenever href_out=0.
- frame_done_out: single clk_in pulse on the tick where href_out falls at the end of active line V_LINES-1.
- Pixel x counts 0..H_PIXELS-1 and y counts 0..V_LINES-1, both widths $clog2. Patterns (latched per frame):
  - 0 colour bars: bar = x*8/H_PIXELS. Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1 gradient: {x[4:0], x[5:0], x[4:0]}.
  - 2 checker: (x[4]^y[4]) ? FFFF : 0000.
  - 3 coordinate: {y[7:0], x[7:0]}.
- Counter widths must cover (VSYNC_LINES+V_BACK+V_LINES+V_FRONT)*LT without overflow. No wrap-around within a frame.

Optional Feature:
- Macro CAM_STREAM_EXT_EN.
- When defined:
  - Adds ports pixel_req_out (output 1) and pixel_in (input 16).
  - pixel_req_out pulses one clk_in cycle at the tick that emits a pixel's high byte.
  - pixel_in is sampled exactly CLK_DIV/2 clk_in cycles later, before the next tick. Both bytes of the pixel come from that sample.
  - pattern_sel_in=3 selects the external source instead of the coordinate pattern.
- When undefined: no extra ports; behaviour exactly as above.

Test Plan:
- Params H_PIXELS=4, V_LINES=2, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, CLK_DIV=2; enable_in=1 → frame period = 60 pclk ticks (120 clk_in). vsync high 12 ticks; first href rise at tick 24, href high 8 ticks; frame_done_out asserted once per 120 cycles.
- Same params, pattern 3 → bytes on line 1 are 01,00,01,01,01,02,01,03.
- Defaults, pattern 0 → pixel 0 = FF,FF; pixel 40 = FF,E0; pixel 319 = 00,00.
- Drop enable_in midway through an active line → current frame completes including VFRONT; then IDLE with vsync/href low; pclk_out keeps toggling.
- Assert rst_n_in=0 mid-line → all outputs 0 in the same cycle (asynchronous); after release, generation restarts with vsync, never mid-line.
- Change pattern_sel_in mid-frame → current frame content unchanged; new pattern starts on the next vsync.
